out_display: RTL and testbench

- Sits directly downstream of the SAP1 output register and consumes its WIDTH-bit `o_data`.
- Converts the value to BCD with a sequential double-dabble engine.
- Drives a multiplexed, common-anode 7-segment display: one digit lit at a time, scanned continuously.
- Runs on every mclk edge, independent of mclk_en, so the display stays alive while the CPU clock is gated or halted.

---
 rtl/out_display_pkg.sv | 38 +++
 rtl/out_display_bcd_to_seg7.sv | 28 ++
 rtl/out_display.sv | 186 ++++++++++++++++++
 tb/tb_out_display.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/out_display_pkg.sv
// Shared definitions for the out_display slice: active-low 7-segment
// patterns ({g,f,e,d,c,b,a}), converter FSM states and a sizing helper.
package out_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Number of decimal digits needed to show 2^width-1.
    function automatic int unsigned min_digits(input int unsigned width);
        longint unsigned maxv;
        int unsigned     n;
        maxv = (64'd1 << width) - 64'd1;
        n    = 1;
        for (int unsigned i = 0; i < 20; i++) begin
            if (maxv >= 64'd10) begin
                maxv = maxv / 64'd10;
                n    = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/out_display_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern decoder.
// Codes 10..15 never occur in valid BCD and decode to all segments off.
module bcd_to_seg7
    import out_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup for one digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/out_display.sv
// Output-register display driver: sequential double-dabble binary->BCD
// conversion feeding a continuously scanned, common-anode 7-segment display.
// Runs on every mclk edge so the display stays alive while the CPU is halted.
// Optional macro OUT_DISPLAY_BLANK_EN: blank leading-zero digits (digit 0
// is never blanked; blanked anodes still strobe).
module out_display
    import out_display_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 1024
)
(
    input  logic                  mclk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      i_data,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_busy,
    output logic [6:0]            o_seg,
    output logic [DIGITS-1:0]     o_an
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned BIT_W  = $clog2(WIDTH + 1);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("out_display: DIGITS too small to represent 2^WIDTH-1");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan
        $error("out_display: SCAN_DIV must be at least 2");
    end

    // Converter state
    state_t                   state, state_nxt;
    logic [WIDTH-1:0]         last_val, last_nxt;
    logic [WIDTH-1:0]         shreg, sh_nxt;
    logic [BCD_W-1:0]         scratch, scr_nxt;
    logic [BCD_W-1:0]         adj;
    logic [BCD_W+WIDTH-1:0]   dd_shift;
    logic [BIT_W-1:0]         bit_cnt, bit_nxt;
    logic [BCD_W-1:0]         bcd_nxt;
    logic                     busy_nxt;

    // Scanner state
    logic [SCAN_W-1:0]        scan_cnt;
    logic [IDX_W-1:0]         idx;
    logic [3:0]               cur_nib;
    logic [6:0]               dec_seg;
    logic [6:0]               seg_nxt;
    logic [DIGITS-1:0]        an_nxt;

    // FSM state register
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Double-dabble correction: add 3 to every scratch nibble >= 5
    always_comb begin
        adj = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
    end

    // Next-state and datapath next values for the converter
    always_comb begin
        state_nxt = state;
        last_nxt  = last_val;
        sh_nxt    = shreg;
        scr_nxt   = scratch;
        bit_nxt   = bit_cnt;
        bcd_nxt   = o_bcd;
        busy_nxt  = o_busy;
        dd_shift  = {adj, shreg} << 1;
        case (state)
            IDLE: begin
                if (i_data != last_val) begin
                    sh_nxt    = i_data;
                    scr_nxt   = '0;
                    last_nxt  = i_data;
                    bit_nxt   = BIT_W'(WIDTH);
                    busy_nxt  = 1'b1;
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                scr_nxt = dd_shift[BCD_W+WIDTH-1:WIDTH];
                sh_nxt  = dd_shift[WIDTH-1:0];
                bit_nxt = bit_cnt - 1'b1;
                if (bit_cnt == BIT_W'(1))
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                bcd_nxt   = scratch;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Converter datapath and registered conversion outputs
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            last_val <= '0;
            shreg    <= '0;
            scratch  <= '0;
            bit_cnt  <= '0;
            o_bcd    <= '0;
            o_busy   <= 1'b0;
        end else begin
            last_val <= last_nxt;
            shreg    <= sh_nxt;
            scratch  <= scr_nxt;
            bit_cnt  <= bit_nxt;
            o_bcd    <= bcd_nxt;
            o_busy   <= busy_nxt;
        end
    end

    // Select the nibble for the digit currently being scanned
    always_comb begin
        cur_nib = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (idx == IDX_W'(d))
                cur_nib = o_bcd[4*d +: 4];
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_nib),
        .seg (dec_seg)
    );

`ifdef OUT_DISPLAY_BLANK_EN
    logic lead_zero;

    // Blank a digit when it and every digit above it are zero (never digit 0)
    always_comb begin
        lead_zero = 1'b1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if ((32'(idx) <= d) && (o_bcd[4*d +: 4] != 4'd0))
                lead_zero = 1'b0;
        end
        seg_nxt = ((idx != '0) && lead_zero) ? SEG_BLANK : dec_seg;
    end
`else
    // All digits decoded, leading zeros shown
    always_comb begin
        seg_nxt = dec_seg;
    end
`endif

    // One-hot active-low anode for the current digit
    always_comb begin
        an_nxt = '1;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (idx == IDX_W'(d))
                an_nxt[d] = 1'b0;
        end
    end

    // Scan timing; anode and segments register together from the same index
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            o_seg    <= SEG_BLANK;
            o_an     <= '1;
        end else begin
            o_seg <= seg_nxt;
            o_an  <= an_nxt;
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_display.sv
// Scoreboard bench for out_display: stimulus queues the decimal values it
// expects the display to commit, a monitor pops them on each busy fall and
// also checks the scanned anode/segment outputs against a decimal model.
module tb_out_display;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DIGITS   = 3;
    localparam int unsigned SCAN_DIV = 4;

    localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic              mclk   = 1'b0;
    logic              rst_n  = 1'b0;
    logic [WIDTH-1:0]  i_data = '0;
    logic [11:0]       o_bcd;
    logic              o_busy;
    logic [6:0]        o_seg;
    logic [2:0]        o_an;

    out_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .mclk   (mclk),
        .rst_n  (rst_n),
        .i_data (i_data),
        .o_bcd  (o_bcd),
        .o_busy (o_busy),
        .o_seg  (o_seg),
        .o_an   (o_an)
    );

    always #5 mclk = ~mclk;

    int          total = 0;
    int          bad   = 0;
    int unsigned exp_q[$];
    int unsigned shown    = 0;
    int unsigned last_drv = 0;
    int unsigned k        = 0;
    int unsigned busy_len = 0;
    logic        prev_busy = 1'b0;

    function automatic int unsigned pow10(input int unsigned d);
        int unsigned r = 1;
        for (int unsigned i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int unsigned v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int unsigned v, input int unsigned d);
`ifdef OUT_DISPLAY_BLANK_EN
        if (d > 0 && v < pow10(d)) return 7'h7F;
`endif
        return PAT[(v / pow10(d)) % 10];
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edges since reset release, for the scan model
    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Monitor: reset values, scan outputs, busy width and committed results
    always @(negedge mclk) begin
        if (!rst_n) begin
            exp_q.delete();
            shown     = 0;
            busy_len  = 0;
            prev_busy = 1'b0;
            check("rst_bcd", o_bcd, 0);
            check("rst_busy", o_busy, 0);
            check("rst_seg", o_seg, 7'h7F);
            check("rst_an", o_an, 3'b111);
        end else begin
            if (k == 0) begin
                check("pre_scan_seg", o_seg, 7'h7F);
                check("pre_scan_an", o_an, 3'b111);
            end else begin
                int unsigned dg;
                logic [2:0]  ea;
                dg = ((k - 1) / SCAN_DIV) % DIGITS;
                ea = ~(3'b001 << dg);
                check("scan_an", o_an, ea);
                check("scan_seg", o_seg, exp_seg(shown, dg));
            end
            if (o_busy) begin
                busy_len++;
            end else if (prev_busy) begin
                check("busy_len", busy_len, WIDTH + 1);
                busy_len = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: got %0h expected none", o_bcd);
                end else begin
                    shown = exp_q.pop_front();
                end
            end
            prev_busy = o_busy;
            check("o_bcd", o_bcd, to_bcd(shown));
        end
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic drive(input int unsigned v);
        @(negedge mclk);
        i_data = v[WIDTH-1:0];
        if (v != last_drv) exp_q.push_back(v);
        last_drv = v;
    endtask

    task automatic wait_busy();
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge mclk);
            if (o_busy) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL busy_rise: got 0 expected 1 within 30 cycles");
        end
    endtask

    task automatic settle();
        int unsigned lows = 0;
        for (int i = 0; i < 300 && lows < 3; i++) begin
            @(negedge mclk);
            lows = o_busy ? 0 : lows + 1;
        end
        total++;
        if (lows < 3) begin
            bad++;
            $display("FAIL settle_timeout: got busy expected idle");
        end
    endtask

    task automatic hold(input int unsigned n);
        int unsigned hi = 0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge mclk);
            if (o_busy) hi++;
        end
        check("hold_busy", hi, 0);
    endtask

    // a converts, then b is applied kk cycles into that conversion
    task automatic mid_change(input int unsigned a, input int unsigned b, input int unsigned kk);
        int unsigned gap = 0;
        drive(a);
        wait_busy();
        cyc(kk);
        i_data = b[WIDTH-1:0];
        exp_q.push_back(b);
        last_drv = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge mclk);
            if (!o_busy) break;
        end
        gap = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge mclk);
            if (o_busy) break;
            gap++;
        end
        check("busy_gap", gap, 1);
        settle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned v, b;
        // Reset with zero input: no conversion, zeros scanned
        cyc(3);
        @(posedge mclk);
        #2 rst_n = 1'b1;
        hold(30);

        // Full-scale value
        drive(255);
        settle();
        hold(24);

        // Change during conversion
        mid_change(42, 7, 2);
        hold(24);

        // Reset mid-conversion
        drive(100);
        wait_busy();
        cyc(3);
        @(posedge mclk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_bcd", o_bcd, 0);
        check("abort_busy", o_busy, 0);
        check("abort_seg", o_seg, 7'h7F);
        check("abort_an", o_an, 3'b111);
        @(posedge mclk);
        #2 rst_n = 1'b1;
        last_drv = 0;
        if (i_data != '0) exp_q.push_back(i_data);
        last_drv = i_data;
        settle();
        hold(24);

        // Leading-zero cases
        drive(7);
        settle();
        hold(24);
        drive(0);
        settle();
        hold(24);

        // Randomized values, some changed mid-conversion
        for (int it = 0; it < 40; it++) begin
            do v = $urandom_range(0, 255); while (v == last_drv);
            if ($urandom_range(0, 2) == 0) begin
                do b = $urandom_range(0, 255); while (b == v);
                mid_change(v, b, $urandom_range(0, 8));
            end else begin
                drive(v);
                settle();
            end
            hold($urandom_range(0, 15));
        end

        // Long stable hold
        hold(1000);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
